pc_packer_rr: RTL
=================

Name: pc_packer_rr

Overview:
- Parametrised N-input upward packer and merger.
- Packs each input word as {route, code, payload}. Per input, the route is either forced to the go-home route or taken from the input.
- Merges all inputs into one output channel toward the PC, using round-robin arbitration.
- Keeps multi-word packets contiguous (for example, 2-word filtered events and 2-word heartbeats).
- Replaces the fixed two-level merge tree with fair, packet-atomic merging behind a registered output buffer.

Parameters:
- NIN, 3, number of input streams (≥1).
- NPCcode, 7, code field width.
- NPCdata, 20, payload field width.
- NPCroute, 5, route field width.
- GO_HOME_RT, 0, route value inserted for inputs not passing their own route (NPCroute bits).
- ROUTE_EN, 0, NIN-bit mask: bit i=1 means input i passes in_route; bit i=0 means GO_HOME_RT is forced.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- in_route  in  NIN*NPCroute  per-input route, slice i = input i.
- in_code  in  NIN*NPCcode  per-input code.
- in_payload  in  NIN*NPCdata  per-input payload.
- in_last  in  NIN  1 = final word of a packet.
- in_v  in  NIN  per-input valid.
- in_a  out  NIN  per-input acknowledge.
- out_d  out  NPCroute+NPCcode+NPCdata  packed word.
- out_v  out  1  output valid.
- out_a  in  1  output acknowledge.
- lock_idx  out  clog2(NIN) (min 1)  input currently holding a packet lock.
- locked  out  1  lock active.

Behaviour:
- One clock, clk. Reset is synchronous and active-high, named reset.
- Transfer rule: a transfer occurs on any channel in a cycle where v&&a. Senders hold v and data stable until the transfer.
- Packing: W = NPCroute+NPCcode+NPCdata. Word = {ROUTE_EN[i] ? in_route[i] : GO_HOME_RT, in_code[i], in_payload[i]}. The MSB is the route; the code and payload are unmodified.
- Output buffer: 2-entry FIFO. out_v = not empty; out_d = head entry.
  - Pop on out_v&&out_a.
  - Push on the granted input's transfer.
  - Latency: a word accepted at edge k appears on out_v/out_d after edge k, i.e. 1 cycle.
- Acknowledge: in_a[i] = grant[i] && (count<2).
  - No combinational path from out_a to in_a.
  - A full FIFO (count=2) accepts nothing, even while popping.
  - With count=1 and simultaneous push+pop, throughput is 1 word per cycle.
- Arbiter FSM, IDLE:
  - Grant goes to the first i with in_v[i]=1, searching from ptr upward and wrapping modulo NIN.
  - Transfer with in_last=1: ptr <= (i+1) mod NIN; stay IDLE.
  - Transfer with in_last=0: go to LOCKED with lock_idx=i.
- Arbiter FSM, LOCKED:
  - Only lock_idx is granted. Other inputs wait regardless of their in_v.
  - Transfer with in_last=1 → IDLE, ptr <= (lock_idx+1) mod NIN.
- Grant changes only on transfer edges. A grant is never withdrawn while in_v is held.
- NIN=1: ptr fixed at 0; lock is still tracked.
- Reset values: ptr=0, FSM=IDLE, locked=0, lock_idx=0, FIFO empty, out_v=0, out_d=0, in_a=0 (while reset is high).
- Reset mid-packet: the lock is dropped and the FIFO is flushed. Words already accepted are lost; upstream is also reset.

Decomposition:
- Package pc_packer_pkg:
  - Function pc_word_w(route, code, data).
  - Arbiter state enum {IDLE, LOCKED}.
  - Default field widths and GO_HOME_RT constant shared with serializers and parsers.
- Sub-module pc_skid_fifo2: 2-entry FIFO, parametrised width, push/pop/count, synchronous reset.
- The arbiter, FSM and packing stay in pc_packer_rr.

Test Plan:
- Single input, ROUTE_EN=0: input 0 code=7'h03, payload=20'h12345, last=1, out_a=1. Response: one cycle later out_v=1, out_d={5'h00,7'h03,20'h12345}, in_a[0]=1 in the accept cycle.
- All three inputs valid, single-word packets, out_a=1, 12 cycles. Response: output input order 0,1,2,0,1,2,…; one word per cycle after the first.
- Input 1 sends a 2-word packet (last=0 then 1) while inputs 0 and 2 are valid, ptr=1. Response: words 1a,1b are contiguous; locked=1, lock_idx=1 between them; next grant is 2.
- out_a=0 for 5 cycles with all inputs valid. Response: the FIFO holds 2 words, all in_a=0 from the third cycle on. After out_a=1, there is no loss or duplication and order is preserved.
- ROUTE_EN=3'b100, in_route[2]=5'h1F, in_route[0]=5'h0A. Response: route field is 5'h1F for input 2 words and 5'h00 for input 0 words.
- Reset for 1 cycle while LOCKED on input 1 with 1 word buffered. Response: next cycle out_v=0, locked=0. With inputs 0 and 1 valid, input 0 is granted first (ptr=0).

Source files
------------

// File: rtl/pc_packer_pkg.sv
// pc_packer_pkg: shared field widths, go-home route and arbiter state for the PC uplink packer
package pc_packer_pkg;
  localparam int NPC_CODE_W = 7;
  localparam int NPC_DATA_W = 20;
  localparam int NPC_ROUTE_W = 5;
  localparam logic [NPC_ROUTE_W-1:0] GO_HOME_RT_DEF = '0;
  typedef enum logic {IDLE, LOCKED} arb_state_e;
  function automatic int pc_word_w(int route, int code, int data);
    return route + code + data;
  endfunction
endpackage

// File: rtl/pc_skid_fifo2.sv
// pc_skid_fifo2: two-entry output buffer with push/pop/count
module pc_skid_fifo2 #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic [1:0]   count
);
  logic [W-1:0] r_mem [2];
  logic         r_wp, r_rp;
  logic [1:0]   r_cnt;
  logic         w_push, w_pop;
  assign w_push = push && r_cnt != 2'd2;
  assign w_pop  = pop && r_cnt != 2'd0;
  assign dout   = r_mem[r_rp];
  assign count  = r_cnt;
  // storage, pointers and occupancy; a full buffer refuses writes even while draining
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mem <= '{default: '0};
      r_wp  <= 1'b0;
      r_rp  <= 1'b0;
      r_cnt <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wp] <= din;
        r_wp        <= ~r_wp;
      end
      if (w_pop) r_rp <= ~r_rp;
      r_cnt <= r_cnt + 2'(w_push) - 2'(w_pop);
    end
  end
endmodule

// File: rtl/pc_packer_rr.sv
// pc_packer_rr: packs N input streams and merges them round-robin, packet-atomic, into one PC channel
module pc_packer_rr
  import pc_packer_pkg::*;
#(
  parameter int NIN = 3,
  parameter int NPCcode = NPC_CODE_W,
  parameter int NPCdata = NPC_DATA_W,
  parameter int NPCroute = NPC_ROUTE_W,
  parameter logic [NPCroute-1:0] GO_HOME_RT = GO_HOME_RT_DEF,
  parameter logic [NIN-1:0] ROUTE_EN = '0
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [NIN*NPCroute-1:0]                in_route,
  input  logic [NIN*NPCcode-1:0]                 in_code,
  input  logic [NIN*NPCdata-1:0]                 in_payload,
  input  logic [NIN-1:0]                         in_last,
  input  logic [NIN-1:0]                         in_v,
  output logic [NIN-1:0]                         in_a,
  output logic [NPCroute+NPCcode+NPCdata-1:0]    out_d,
  output logic                                   out_v,
  input  logic                                   out_a,
  output logic [(NIN > 1 ? $clog2(NIN) : 1)-1:0] lock_idx,
  output logic                                   locked
);
  localparam int W = pc_word_w(NPCroute, NPCcode, NPCdata);
  localparam int IW = NIN > 1 ? $clog2(NIN) : 1;
  function automatic logic [IW-1:0] wrap_add(logic [IW-1:0] a, int b);
    int s;
    s = int'(a) + b;
    return IW'(s >= NIN ? s - NIN : s);
  endfunction
  arb_state_e    r_state;
  logic [IW-1:0] r_ptr, r_lock_idx, r_pend_idx;
  logic          r_pend;
  logic [W-1:0]  w_word [NIN];
  logic [IW-1:0] w_srch_idx, w_gnt_idx;
  logic          w_srch_v, w_pend_ok, w_gnt_v, w_xfer;
  logic [NIN-1:0] w_gnt;
  logic [1:0]    w_count;
  for (genvar i = 0; i < NIN; i++) begin : g_pack
    assign w_word[i] = {ROUTE_EN[i] ? in_route[i*NPCroute +: NPCroute] : GO_HOME_RT,
                        in_code[i*NPCcode +: NPCcode], in_payload[i*NPCdata +: NPCdata]};
  end
  // first valid input at or after ptr, wrapping; scanned downward so the nearest one wins
  always_comb begin
    w_srch_idx = '0;
    w_srch_v   = 1'b0;
    for (int k = NIN - 1; k >= 0; k--) begin
      if (in_v[wrap_add(r_ptr, k)]) begin
        w_srch_v   = 1'b1;
        w_srch_idx = wrap_add(r_ptr, k);
      end
    end
  end
  // an offered-but-stalled grant is held so a newly valid input cannot steal it
  assign w_pend_ok = r_pend && in_v[r_pend_idx];
  assign w_gnt_idx = r_state == LOCKED ? r_lock_idx : w_pend_ok ? r_pend_idx : w_srch_idx;
  assign w_gnt_v   = r_state == LOCKED || w_pend_ok || w_srch_v;
  assign w_gnt     = w_gnt_v ? NIN'(1) << w_gnt_idx : '0;
  assign in_a      = (reset || w_count == 2'd2) ? '0 : w_gnt;
  assign w_xfer    = |(in_v & in_a);
  assign out_v     = w_count != 2'd0;
  assign locked    = r_state == LOCKED;
  assign lock_idx  = r_lock_idx;
  // arbiter: single-word packets advance the pointer, multi-word packets lock the source until last
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_ptr      <= '0;
      r_lock_idx <= '0;
      r_pend     <= 1'b0;
      r_pend_idx <= '0;
    end else begin
      r_pend     <= r_state == IDLE && w_gnt_v && !w_xfer;
      r_pend_idx <= w_gnt_idx;
      if (w_xfer) begin
        if (in_last[w_gnt_idx]) begin
          r_state <= IDLE;
          r_ptr   <= wrap_add(w_gnt_idx, 1);
        end else begin
          r_state    <= LOCKED;
          r_lock_idx <= w_gnt_idx;
        end
      end
    end
  end
  pc_skid_fifo2 #(.W(W)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(w_xfer),
    .pop(out_v && out_a),
    .din(w_word[w_gnt_idx]),
    .dout(out_d),
    .count(w_count)
  );
endmodule
